// File: rtl/bcd_display_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_display_ctrl
//   Sequential binary-to-BCD converter (double dabble, one bit per cycle)
//   feeding a 6-digit time-multiplexed seven-segment scan controller.
//
// Configuration macro:
//   LEADING_ZERO_BLANK_EN - when defined, leading-zero digits 5..1 are shown
//                           blank; digit0 always displays.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   in_data valid this cycle
//   in_data   in   WIDTH-bit binary word to convert
//   in_ready  out  converter idle; word accepted on in_valid && in_ready
//   busy      out  conversion in progress
//   done      out  one-cycle pulse while bcd has just been updated
//   bcd       out  latched digits, [23:20]=digit5 .. [3:0]=digit0
//   seg       out  {g,f,e,d,c,b,a} active-low for the scanned digit
//   an        out  active-low one-hot-zero digit enables
// ---------------------------------------------------------------------------
`ifndef WORDSIZE
`define WORDSIZE 8
`endif

module bcd_display_ctrl #(
  parameter int unsigned WIDTH    = `WORDSIZE,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [23:0]      bcd,
  output logic [6:0]       seg,
  output logic [5:0]       an
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        r_state;
  logic [WIDTH-1:0]  r_data;
  logic [23:0]       r_work;
  logic [4:0]        r_cnt;
  logic [23:0]       r_bcd;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [2:0]        r_idx;

  logic              w_accept;
  logic [23:0]       w_adj;
  logic [23:0]       w_work_nxt;
  logic [3:0]        w_digit;
  logic              w_blank;

  assign w_accept = in_valid && (r_state == S_IDLE);

  // Add-3 correction on every nibble, then shift in the next data MSB.
  always_comb begin
    w_adj = r_work;
    for (int k = 0; k < 6; k++) begin
      if (r_work[k*4 +: 4] >= 4'd5) begin
        w_adj[k*4 +: 4] = r_work[k*4 +: 4] + 4'd3;
      end
    end
    w_work_nxt = {w_adj[22:0], r_data[WIDTH-1]};
  end

  // Conversion FSM and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_data  <= in_data;
            r_work  <= '0;
            r_cnt   <= 5'(WIDTH);
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_work <= w_work_nxt;
          r_data <= r_data << 1;
          r_cnt  <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            // Latch the final result on the last shift so bcd is already
            // valid during the DONE cycle in which done is asserted.
            r_bcd   <= w_work_nxt;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Free-running digit scan, independent of the converter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      r_scan_cnt <= '0;
      r_idx      <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  always_comb begin
    case (r_idx)
      3'd0:    w_digit = r_bcd[3:0];
      3'd1:    w_digit = r_bcd[7:4];
      3'd2:    w_digit = r_bcd[11:8];
      3'd3:    w_digit = r_bcd[15:12];
      3'd4:    w_digit = r_bcd[19:16];
      3'd5:    w_digit = r_bcd[23:20];
      default: w_digit = 4'hF;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [5:0] w_hi_zero;

  // w_hi_zero[k]: digit k and every higher digit are zero.
  always_comb begin
    w_hi_zero    = '0;
    w_hi_zero[5] = (r_bcd[23:20] == 4'd0);
    for (int k = 4; k >= 0; k--) begin
      w_hi_zero[k] = w_hi_zero[k+1] && (r_bcd[k*4 +: 4] == 4'd0);
    end
  end

  always_comb begin
    w_blank = 1'b0;
    if (r_idx != 3'd0 && r_idx <= 3'd5) begin
      w_blank = w_hi_zero[r_idx];
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    if (w_blank) begin
      seg = 7'h7F;
    end else begin
      case (w_digit)
        4'd0:    seg = 7'h40;
        4'd1:    seg = 7'h79;
        4'd2:    seg = 7'h24;
        4'd3:    seg = 7'h30;
        4'd4:    seg = 7'h19;
        4'd5:    seg = 7'h12;
        4'd6:    seg = 7'h02;
        4'd7:    seg = 7'h78;
        4'd8:    seg = 7'h00;
        4'd9:    seg = 7'h10;
        default: seg = 7'h7F;
      endcase
    end
  end

  assign an       = ~(6'b000001 << r_idx);
  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign bcd      = r_bcd;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
module tb_bcd_display_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [23:0] bcd;
  logic [6:0]  seg;
  logic [5:0]  an;

  int n_checks = 0;
  int n_errors = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  bcd_display_ctrl #(
    .WIDTH    (8),
    .SCAN_DIV (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .seg      (seg),
    .an       (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present v for one accept edge and wait for done; checks latency and result.
  task automatic convert(input string tag, input logic [7:0] v, input logic [23:0] prev,
                         input logic [23:0] exp);
    int n;
    int pulses;
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_hold"}, 32'(bcd), 32'(prev));
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, 8);
    check({tag, "_bcd"}, 32'(bcd), 32'(exp));
    check({tag, "_rdy_lo"}, 32'(in_ready), 32'd0);
    tick();
    check({tag, "_rdy_hi"}, 32'(in_ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) pulses++;
      tick();
    end
    check({tag, "_one_pulse"}, pulses, 0);
  endtask

  // Align to the start of slot 0, then walk two full scan rotations.
  task automatic scan_walk(input string tag, input logic [41:0] exp_seg);
    logic [5:0] prev;
    logic       found;
    found = 1'b0;
    prev  = an;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (an == 6'b111110 && prev != 6'b111110) found = 1'b1;
      prev = an;
    end
    check({tag, "_sync"}, 32'(found), 32'd1);
    for (int c = 0; c < 48; c++) begin
      check({tag, "_an"}, 32'(an), 32'(6'(~(6'b000001 << ((c % 24) / 4)))));
      check({tag, "_seg"}, 32'(seg), 32'(exp_seg[((c % 24) / 4) * 7 +: 7]));
      tick();
    end
  endtask

  initial begin
    int n;
    int pulses;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #12;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_an", 32'(an), 32'(6'b111110));
    check("rst_seg", 32'(seg), 32'h40);
    tick();
    rst_n = 1'b1;
    tick();

    convert("c255", 8'd255, 24'h000000, 24'h000255);
    convert("c0", 8'd0, 24'h000255, 24'h000000);
    convert("c128", 8'd128, 24'h000000, 24'h000128);

    // in_valid held high through a conversion: only the first word is taken.
    in_valid = 1'b1;
    in_data  = 8'd99;
    tick();
    in_data = 8'd42;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("hold_lat", n, 8);
    check("hold_bcd99", 32'(bcd), 32'h000099);
    tick();
    check("hold_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("hold_busy42", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("hold_lat42", n, 8);
    check("hold_bcd42", 32'(bcd), 32'h000042);
    tick();

    // Reset in the middle of a conversion.
    in_valid = 1'b1;
    in_data  = 8'd200;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_bcd", 32'(bcd), 32'd0);
    check("arst_an", 32'(an), 32'(6'b111110));
    check("arst_done", 32'(done), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) pulses++;
      tick();
    end
    check("arst_nodone", pulses, 0);
    check("arst_bcd_after", 32'(bcd), 32'd0);

    convert("s255", 8'd255, 24'h000000, 24'h000255);
    scan_walk("scan255", {LZ, LZ, LZ, 7'h24, 7'h12, 7'h12});
    convert("s7", 8'd7, 24'h000255, 24'h000007);
    scan_walk("scan7", {LZ, LZ, LZ, LZ, LZ, 7'h78});
    convert("s0", 8'd0, 24'h000007, 24'h000000);
    scan_walk("scan0", {LZ, LZ, LZ, LZ, LZ, 7'h40});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
